iagc_controller: RTL and testbench

Top-level sequencer of the IAGC core. It produces the 4-bit status code that drives the command decoder and dispatches decoded commands: reset, sample capture with decimation, decimation set, memory clean and memory dump. It owns the sample-memory address and write strobe and the UART transmit handshake for dumps. It sits between the UART receiver/transmitter, the command decoder and the sample RAM.

---
 rtl/iagc_controller.sv | 171 +++++++++++++++++
 tb/tb_iagc_controller.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iagc_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// iagc_controller : IAGC sequencer - command dispatch, capture, clean and dump
// Revision 1.0
// ----------------------------------------------------------------------------
module iagc_controller #(
    parameter int IAGC_STATUS_SIZE = 4,
    parameter int DATA_SIZE        = 8,
    parameter int ADDR_SIZE        = 10,
    parameter int INIT_CYCLES      = 16
) (
    input  logic                        i_clock,
    input  logic                        i_reset_n,
    input  logic                        i_rx_valid,
    input  logic                        i_cmd_reset,
    input  logic                        i_cmd_sample,
    input  logic                        i_cmd_set_decim,
    input  logic                        i_cmd_clean_mem,
    input  logic                        i_cmd_dump_mem,
    input  logic [DATA_SIZE-1:0]        i_cmd_param,
    input  logic                        i_sample_valid,
    input  logic                        i_tx_ready,
    output logic [IAGC_STATUS_SIZE-1:0] o_iagc_status,
    output logic [ADDR_SIZE-1:0]        o_mem_addr,
    output logic                        o_mem_we,
    output logic                        o_mem_clear,
    output logic                        o_tx_valid,
    output logic [3:0]                  o_decim,
    output logic                        o_cmd_error
);

    typedef enum logic [3:0] {
        ST_RESET     = 4'b0000,
        ST_INIT      = 4'b0001,
        ST_IDLE      = 4'b0010,
        ST_SAMPLE    = 4'b0011,
        ST_CMD_PARSE = 4'b0100,
        ST_CMD_READ  = 4'b0101,
        ST_CMD_ERROR = 4'b0110,
        ST_DUMP_MEM  = 4'b0111,
        ST_CLEAN_MEM = 4'b1000
    } state_t;

    localparam int                    INIT_W    = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [INIT_W-1:0]     INIT_LAST = INIT_W'(INIT_CYCLES - 1);
    localparam logic [ADDR_SIZE-1:0]  ADDR_LAST = '1;

    state_t                state;
    state_t                state_next;
    logic [INIT_W-1:0]     init_cnt;
    logic [3:0]            decim_cnt;
    logic [3:0]            decim;
    logic [ADDR_SIZE-1:0]  mem_addr;
    logic                  tx_phase;
    logic                  handshake;
    logic                  addr_last;
    logic                  unused_param;

    assign addr_last     = (mem_addr == ADDR_LAST);
    assign o_mem_addr    = mem_addr;
    assign o_decim       = decim;
    assign o_iagc_status = IAGC_STATUS_SIZE'(state);
    assign unused_param  = ^i_cmd_param;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ST_RESET;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        o_mem_we    = 1'b0;
        o_mem_clear = 1'b0;
        o_tx_valid  = 1'b0;
        o_cmd_error = 1'b0;
        handshake   = 1'b0;
        case (state)
            ST_RESET:     state_next = ST_INIT;
            ST_INIT:      if (init_cnt == INIT_LAST) state_next = ST_IDLE;
            ST_IDLE:      if (i_rx_valid) state_next = ST_CMD_READ;
            ST_CMD_READ:  state_next = ST_CMD_PARSE;
            ST_CMD_PARSE: begin
                if (i_cmd_reset)          state_next = ST_RESET;
                else if (i_cmd_sample)    state_next = ST_SAMPLE;
                else if (i_cmd_set_decim) state_next = ST_IDLE;
                else if (i_cmd_clean_mem) state_next = ST_CLEAN_MEM;
                else if (i_cmd_dump_mem)  state_next = ST_DUMP_MEM;
                else                      state_next = ST_CMD_ERROR;
            end
            ST_CMD_ERROR: begin
                o_cmd_error = 1'b1;
                state_next  = ST_IDLE;
            end
            ST_SAMPLE: begin
                // A new command byte preempts capture, including a write due this cycle
                if (i_rx_valid) begin
                    state_next = ST_CMD_READ;
                end else if (i_sample_valid && (decim_cnt == 4'd0)) begin
                    o_mem_we = 1'b1;
                    if (addr_last) state_next = ST_IDLE;
                end
            end
            ST_CLEAN_MEM: begin
                o_mem_we    = 1'b1;
                o_mem_clear = 1'b1;
                if (addr_last) state_next = ST_IDLE;
            end
            ST_DUMP_MEM: begin
                o_tx_valid = tx_phase;
                if (tx_phase && i_tx_ready) begin
                    handshake = 1'b1;
                    if (addr_last) state_next = ST_IDLE;
                end
            end
            default:      state_next = ST_RESET;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            init_cnt  <= '0;
            decim_cnt <= '0;
            decim     <= '0;
            mem_addr  <= '0;
            tx_phase  <= 1'b0;
        end else begin
            case (state)
                ST_RESET: begin
                    init_cnt <= '0;
                    decim    <= '0;
                    mem_addr <= '0;
                    tx_phase <= 1'b0;
                end
                ST_INIT: init_cnt <= init_cnt + 1'b1;
                ST_CMD_PARSE: begin
                    mem_addr  <= '0;
                    decim_cnt <= '0;
                    tx_phase  <= 1'b0;
                    if (!i_cmd_reset && !i_cmd_sample && i_cmd_set_decim)
                        decim <= i_cmd_param[3:0];
                end
                ST_SAMPLE: begin
                    if (!i_rx_valid && i_sample_valid) begin
                        if (decim_cnt == 4'd0) begin
                            decim_cnt <= decim;
                            mem_addr  <= mem_addr + 1'b1;
                        end else begin
                            decim_cnt <= decim_cnt - 1'b1;
                        end
                    end
                end
                ST_CLEAN_MEM: mem_addr <= mem_addr + 1'b1;
                ST_DUMP_MEM: begin
                    // tx_phase low is the RAM read-latency wait slot
                    if (handshake) begin
                        mem_addr <= mem_addr + 1'b1;
                        tx_phase <= 1'b0;
                    end else begin
                        tx_phase <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iagc_controller.sv
`default_nettype none
// Testbench for iagc_controller with a 16-entry sample RAM.
module tb_iagc_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic       cmd_reset = 1'b0, cmd_sample = 1'b0, cmd_set_decim = 1'b0;
    logic       cmd_clean_mem = 1'b0, cmd_dump_mem = 1'b0;
    logic [7:0] cmd_param = 8'h00;
    logic       sample_valid = 1'b0;
    logic       tx_ready = 1'b0;
    logic [3:0] status;
    logic [3:0] mem_addr;
    logic       mem_we, mem_clear, tx_valid, cmd_error;
    logic [3:0] decim;

    int n_cmp = 0;
    int n_err = 0;

    iagc_controller #(
        .IAGC_STATUS_SIZE(4),
        .DATA_SIZE(8),
        .ADDR_SIZE(4),
        .INIT_CYCLES(16)
    ) dut (
        .i_clock(clk),
        .i_reset_n(rst_n),
        .i_rx_valid(rx_valid),
        .i_cmd_reset(cmd_reset),
        .i_cmd_sample(cmd_sample),
        .i_cmd_set_decim(cmd_set_decim),
        .i_cmd_clean_mem(cmd_clean_mem),
        .i_cmd_dump_mem(cmd_dump_mem),
        .i_cmd_param(cmd_param),
        .i_sample_valid(sample_valid),
        .i_tx_ready(tx_ready),
        .o_iagc_status(status),
        .o_mem_addr(mem_addr),
        .o_mem_we(mem_we),
        .o_mem_clear(mem_clear),
        .o_tx_valid(tx_valid),
        .o_decim(decim),
        .o_cmd_error(cmd_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] flags;      // {reset, sample, set_decim, clean_mem, dump_mem}
        logic [7:0] param;
        logic [3:0] exp_status; // state entered after CMD_PARSE
        logic       exp_err;
        int         exp_rec;    // cycles from that state back to IDLE
        logic [3:0] exp_decim;  // decimation once back in IDLE
    } vec_t;

    typedef struct {
        logic       we;
        logic [3:0] addr;
    } wr_t;

    vec_t       vecs[9];
    wr_t        sb[$];
    logic [3:0] dump_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Leaves the bench at negedge+1 of the first cycle of the target state.
    task automatic send_cmd(input logic [4:0] flags, input logic [7:0] param);
        @(negedge clk);
        rx_valid = 1'b1;
        #1;
        chk("idle_before_cmd", 32'(status), 32'(4'h2));
        @(negedge clk);
        rx_valid = 1'b0;
        {cmd_reset, cmd_sample, cmd_set_decim, cmd_clean_mem, cmd_dump_mem} = flags;
        cmd_param = param;
        #1;
        chk("cmd_read", 32'(status), 32'(4'h5));
        @(negedge clk);
        #1;
        chk("cmd_parse", 32'(status), 32'(4'h4));
        @(negedge clk);
        {cmd_reset, cmd_sample, cmd_set_decim, cmd_clean_mem, cmd_dump_mem} = 5'b0;
        #1;
    endtask

    initial begin
        int         steps;
        int         m_cnt;
        logic [3:0] m_addr;
        logic       prev_hs;
        logic       hs;
        wr_t        w;

        vecs[0] = '{5'b00100, 8'h03, 4'h2, 1'b0, 0,   4'h3};
        vecs[1] = '{5'b00000, 8'h00, 4'h6, 1'b1, 1,   4'h3};
        vecs[2] = '{5'b00111, 8'h05, 4'h2, 1'b0, 0,   4'h5};
        vecs[3] = '{5'b00100, 8'hA7, 4'h2, 1'b0, 0,   4'h7};
        vecs[4] = '{5'b00011, 8'h00, 4'h8, 1'b0, 16,  4'h7};
        vecs[5] = '{5'b00001, 8'h00, 4'h7, 1'b0, 32,  4'h7};
        vecs[6] = '{5'b01110, 8'h01, 4'h3, 1'b0, 121, 4'h7};
        vecs[7] = '{5'b11100, 8'h09, 4'h0, 1'b0, 17,  4'h0};
        vecs[8] = '{5'b00101, 8'h0C, 4'h2, 1'b0, 0,   4'hC};

        // Reset and INIT sequence
        @(negedge clk);
        #1;
        chk("rst_status", 32'(status), 32'(4'h0));
        chk("rst_outputs", 32'({mem_we, mem_clear, tx_valid, cmd_error, mem_addr, decim}), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_hold", 32'(status), 32'(4'h0));
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            #1;
            chk("init_status", 32'(status), 32'(4'h1));
            chk("init_outputs", 32'({mem_we, mem_clear, tx_valid, cmd_error, mem_addr, decim}), 32'(0));
        end
        @(negedge clk);
        #1;
        chk("init_to_idle", 32'(status), 32'(4'h2));

        // Dispatch table
        for (int v = 0; v < 9; v++) begin
            send_cmd(vecs[v].flags, vecs[v].param);
            chk($sformatf("vec%0d_target", v), 32'(status), 32'(vecs[v].exp_status));
            chk($sformatf("vec%0d_cmd_error", v), 32'(cmd_error), 32'(vecs[v].exp_err));
            sample_valid = 1'b1;
            tx_ready     = 1'b1;
            #1;
            steps = 0;
            while (status != 4'h2 && steps < 400) begin
                @(negedge clk);
                #1;
                steps++;
            end
            chk($sformatf("vec%0d_back_idle", v), 32'(status), 32'(4'h2));
            chk($sformatf("vec%0d_rec_cycles", v), 32'(steps), 32'(vecs[v].exp_rec));
            chk($sformatf("vec%0d_decim", v), 32'(decim), 32'(vecs[v].exp_decim));
            sample_valid = 1'b0;
            tx_ready     = 1'b0;
        end

        // Decimated capture against scoreboard
        send_cmd(5'b00100, 8'h03);
        chk("decim3_idle", 32'(status), 32'(4'h2));
        chk("decim3_value", 32'(decim), 32'(4'h3));
        send_cmd(5'b01000, 8'h00);
        chk("sample_enter", 32'(status), 32'(4'h3));
        m_cnt  = 0;
        m_addr = 4'h0;
        for (int i = 0; i < 61; i++) begin
            sample_valid = 1'b1;
            if (m_cnt == 0) begin
                sb.push_back('{1'b1, m_addr});
                m_addr = m_addr + 4'h1;
                m_cnt  = 3;
            end else begin
                sb.push_back('{1'b0, 4'h0});
                m_cnt--;
            end
            #1;
            w = sb.pop_front();
            chk($sformatf("sample%0d_we", i), 32'(mem_we), 32'(w.we));
            if (w.we) chk($sformatf("sample%0d_addr", i), 32'(mem_addr), 32'(w.addr));
            @(negedge clk);
        end
        sample_valid = 1'b0;
        #1;
        chk("sample_done_idle", 32'(status), 32'(4'h2));
        chk("sample_addr_wrap", 32'(mem_addr), 32'(0));

        // Capture aborted by a new byte at address 5
        send_cmd(5'b00100, 8'h00);
        send_cmd(5'b01000, 8'h00);
        for (int i = 0; i < 5; i++) begin
            sample_valid = 1'b1;
            #1;
            chk("abort_pre_we", 32'(mem_we), 32'(1));
            @(negedge clk);
        end
        rx_valid = 1'b1;
        #1;
        chk("abort_addr", 32'(mem_addr), 32'(5));
        chk("abort_no_write", 32'(mem_we), 32'(0));
        @(negedge clk);
        rx_valid     = 1'b0;
        sample_valid = 1'b0;
        {cmd_reset, cmd_sample, cmd_set_decim, cmd_clean_mem, cmd_dump_mem} = 5'b00100;
        cmd_param = 8'h03;
        #1;
        chk("abort_cmd_read", 32'(status), 32'(4'h5));
        @(negedge clk);
        #1;
        chk("abort_cmd_parse", 32'(status), 32'(4'h4));
        @(negedge clk);
        {cmd_reset, cmd_sample, cmd_set_decim, cmd_clean_mem, cmd_dump_mem} = 5'b0;
        #1;
        chk("abort_idle", 32'(status), 32'(4'h2));

        // Clean sweep, with a stray byte that must be dropped
        send_cmd(5'b00010, 8'h00);
        for (int i = 0; i < 16; i++) begin
            rx_valid = (i == 7);
            #1;
            chk("clean_status", 32'(status), 32'(4'h8));
            chk("clean_we_clear", 32'({mem_we, mem_clear}), 32'(2'b11));
            chk("clean_addr", 32'(mem_addr), 32'(i));
            @(negedge clk);
        end
        rx_valid = 1'b0;
        #1;
        chk("clean_done_idle", 32'(status), 32'(4'h2));
        chk("clean_done_we", 32'({mem_we, mem_clear}), 32'(0));

        // Dump with random transmitter back-pressure
        send_cmd(5'b00001, 8'h00);
        chk("dump_enter", 32'(status), 32'(4'h7));
        for (int a = 0; a < 16; a++) dump_q.push_back(4'(a));
        steps   = 0;
        prev_hs = 1'b1;
        while (status == 4'h7 && steps < 300) begin
            tx_ready = 1'($urandom_range(0, 1));
            #1;
            if (prev_hs) chk("dump_gap_after_hs", 32'(tx_valid), 32'(0));
            hs = tx_valid & tx_ready;
            if (hs) begin
                if (dump_q.size() > 0) begin
                    chk("dump_addr", 32'(mem_addr), 32'(dump_q.pop_front()));
                end else begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL dump_extra_hs: got handshake at addr %0h expected none", mem_addr);
                end
            end
            prev_hs = hs;
            steps++;
            @(negedge clk);
        end
        tx_ready = 1'b0;
        #1;
        chk("dump_remaining", 32'(dump_q.size()), 32'(0));
        chk("dump_done_idle", 32'(status), 32'(4'h2));
        chk("dump_done_tx_valid", 32'(tx_valid), 32'(0));

        // Asynchronous reset in the middle of a dump
        send_cmd(5'b00001, 8'h00);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("dump_hold_valid", 32'(tx_valid), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_status", 32'(status), 32'(4'h0));
        chk("midrst_tx_valid", 32'(tx_valid), 32'(0));
        chk("midrst_decim", 32'(decim), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        steps = 0;
        while (status != 4'h2 && steps < 40) begin
            @(negedge clk);
            #1;
            steps++;
        end
        chk("midrst_recover_idle", 32'(status), 32'(4'h2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
